// File: rtl/hft_position_tracker_if.sv
// ap_ctrl_hs handshake plus fill inputs and position/PnL outputs of hft_position_tracker.
interface hft_position_tracker_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] fill_side;
  logic [31:0] fill_price;
  logic [31:0] fill_qty;
  logic [31:0] current_position;
  logic [31:0] last_fill_price;
  logic [31:0] last_fill_side;
  logic [31:0] avg_entry_price;
  logic [31:0] realized_pnl;
  logic        limit_breach;

  modport master (
    output ap_start, fill_side, fill_price, fill_qty,
    input  ap_done, ap_idle, ap_ready,
    input  current_position, last_fill_price, last_fill_side,
    input  avg_entry_price, realized_pnl, limit_breach
  );

  modport slave (
    input  ap_start, fill_side, fill_price, fill_qty,
    output ap_done, ap_idle, ap_ready,
    output current_position, last_fill_price, last_fill_side,
    output avg_entry_price, realized_pnl, limit_breach
  );
endinterface

// File: rtl/hft_position_tracker.sv
// Net position, VWAP entry price and realized PnL from one fill per ap_ctrl_hs transaction.
// Define HFT_POS_PNL_EN to build the realized-PnL multiplier and accumulator.
module hft_position_tracker #(
  parameter int unsigned POS_LIMIT = 1000
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  hft_position_tracker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [31:0] side_reg, price_reg, qty_reg;
  logic [31:0] pos_reg, avg_reg;
  logic [63:0] basis_reg;

  logic [63:0] div_q_reg;
  logic [31:0] div_r_reg, div_d_reg;
  logic [5:0]  div_cnt_reg;

  logic [31:0] out_pos_reg, out_avg_reg, out_lprice_reg, out_lside_reg;
  logic        out_breach_reg;

  logic        side_buy, side_sell, calc_noop, pos_flat, same_dir, calc_add, calc_reduce;
  logic [31:0] pos_abs, qty_signed, pos_sum, sum_abs, qty_rem;
  logic [31:0] mul_a, mul_b, avg_new;
  logic [63:0] mul_p, basis_new;

  // Fill classification; one shared multiplier serves open, add, reduce and flip.
  always_comb begin
    side_buy    = (side_reg == 32'd1);
    side_sell   = (side_reg == 32'd2);
    calc_noop   = !(side_buy || side_sell) || (qty_reg == 32'd0);
    pos_flat    = (pos_reg == 32'd0);
    pos_abs     = pos_reg[31] ? (~pos_reg + 32'd1) : pos_reg;
    same_dir    = (side_buy && !pos_reg[31]) || (side_sell && pos_reg[31]);
    calc_add    = !calc_noop && !pos_flat && same_dir;
    calc_reduce = !pos_flat && !same_dir && (qty_reg <= pos_abs);
    qty_signed  = side_buy ? qty_reg : (~qty_reg + 32'd1);
    pos_sum     = pos_reg + qty_signed;
    sum_abs     = pos_sum[31] ? (~pos_sum + 32'd1) : pos_sum;
    qty_rem     = qty_reg - pos_abs;

    mul_a = calc_reduce ? avg_reg : price_reg;
    if (pos_flat || same_dir) begin
      mul_b = qty_reg;
    end else if (calc_reduce) begin
      mul_b = sum_abs;
    end else begin
      mul_b = qty_rem;
    end
    mul_p     = {32'd0, mul_a} * {32'd0, mul_b};
    basis_new = calc_add ? (basis_reg + mul_p) : mul_p;

    if (calc_add) begin
      avg_new = avg_reg;
    end else if (calc_reduce) begin
      avg_new = (sum_abs == 32'd0) ? 32'd0 : avg_reg;
    end else begin
      avg_new = price_reg;
    end
  end

  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_r_next;
  logic [63:0] div_q_next;

  // Restoring divide step: dividend shifts out of the top of q while quotient bits enter at the bottom.
  always_comb begin
    div_shift  = {div_r_reg, div_q_reg[63]};
    div_ge     = (div_shift >= {1'b0, div_d_reg});
    div_r_next = div_ge ? (div_shift[31:0] - div_d_reg) : div_shift[31:0];
    div_q_next = {div_q_reg[62:0], div_ge};
  end

  logic        commit_fill;
  logic [31:0] commit_pos, commit_avg, commit_abs;

  // Values landing in the output registers on the edge that enters DONE.
  always_comb begin
    commit_fill = (state_reg == S_DIV) || ((state_reg == S_CALC) && !calc_noop);
    commit_pos  = ((state_reg == S_CALC) && !calc_noop) ? pos_sum : pos_reg;
    if (state_reg == S_DIV) begin
      commit_avg = div_q_next[31:0];
    end else if ((state_reg == S_CALC) && !calc_noop) begin
      commit_avg = avg_new;
    end else begin
      commit_avg = avg_reg;
    end
    commit_abs = commit_pos[31] ? (~commit_pos + 32'd1) : commit_pos;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.ap_start) state_next = S_CALC;
      S_CALC:  state_next = calc_add ? S_DIV : S_DONE;
      S_DIV:   if (div_cnt_reg == 6'd63) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg      <= S_IDLE;
      side_reg       <= '0;
      price_reg      <= '0;
      qty_reg        <= '0;
      pos_reg        <= '0;
      avg_reg        <= '0;
      basis_reg      <= '0;
      div_q_reg      <= '0;
      div_r_reg      <= '0;
      div_d_reg      <= '0;
      div_cnt_reg    <= '0;
      out_pos_reg    <= '0;
      out_avg_reg    <= '0;
      out_lprice_reg <= '0;
      out_lside_reg  <= '0;
      out_breach_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if ((state_reg == S_IDLE) && bus.ap_start) begin
        side_reg  <= bus.fill_side;
        price_reg <= bus.fill_price;
        qty_reg   <= bus.fill_qty;
      end

      if ((state_reg == S_CALC) && !calc_noop) begin
        pos_reg   <= pos_sum;
        avg_reg   <= avg_new;
        basis_reg <= basis_new;
      end

      if (state_reg == S_CALC) begin
        div_q_reg   <= basis_new;
        div_r_reg   <= '0;
        div_d_reg   <= sum_abs;
        div_cnt_reg <= '0;
      end

      if (state_reg == S_DIV) begin
        div_q_reg   <= div_q_next;
        div_r_reg   <= div_r_next;
        div_cnt_reg <= div_cnt_reg + 6'd1;
        if (div_cnt_reg == 6'd63) avg_reg <= div_q_next[31:0];
      end

      if (state_next == S_DONE) begin
        out_pos_reg    <= commit_pos;
        out_avg_reg    <= commit_avg;
        out_breach_reg <= (commit_abs > POS_LIMIT);
        if (commit_fill) begin
          out_lprice_reg <= price_reg;
          out_lside_reg  <= side_reg;
        end
      end
    end
  end

`ifdef HFT_POS_PNL_EN
  logic [63:0] pnl_acc_reg, pnl_diff, pnl_prod, pnl_new, pnl_commit;
  logic [31:0] close_qty, pnl_sat, out_pnl_reg;

  // Two's-complement low 64 bits of (price - avg) * close are exact since the product fits.
  always_comb begin
    close_qty  = calc_reduce ? qty_reg : pos_abs;
    pnl_diff   = {32'd0, price_reg} - {32'd0, avg_reg};
    pnl_prod   = pnl_diff * {32'd0, close_qty};
    pnl_new    = pnl_acc_reg + (pos_reg[31] ? (~pnl_prod + 64'd1) : pnl_prod);
    pnl_commit = ((state_reg == S_CALC) && !calc_noop && !pos_flat && !same_dir)
                 ? pnl_new : pnl_acc_reg;
    if ($signed(pnl_commit) > 64'sd2147483647) begin
      pnl_sat = 32'h7FFF_FFFF;
    end else if ($signed(pnl_commit) < -64'sd2147483648) begin
      pnl_sat = 32'h8000_0000;
    end else begin
      pnl_sat = pnl_commit[31:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pnl_acc_reg <= '0;
      out_pnl_reg <= '0;
    end else begin
      if (state_reg == S_CALC) pnl_acc_reg <= pnl_commit;
      if (state_next == S_DONE) out_pnl_reg <= pnl_sat;
    end
  end

  assign bus.realized_pnl = out_pnl_reg;
`else
  assign bus.realized_pnl = 32'd0;
`endif

  assign bus.ap_done          = (state_reg == S_DONE);
  assign bus.ap_idle          = (state_reg == S_IDLE);
  assign bus.ap_ready         = (state_reg == S_IDLE);
  assign bus.current_position = out_pos_reg;
  assign bus.avg_entry_price  = out_avg_reg;
  assign bus.last_fill_price  = out_lprice_reg;
  assign bus.last_fill_side   = out_lside_reg;
  assign bus.limit_breach     = out_breach_reg;
endmodule

// File: tb/tb_hft_position_tracker.sv
// Table-driven bench for hft_position_tracker with a scoreboard queue and multi-cycle corner sequences.
module tb_hft_position_tracker;
  logic ap_clk = 1'b0;
  logic ap_rst;

  hft_position_tracker_if bus ();

  hft_position_tracker #(.POS_LIMIT(1000)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

`ifdef HFT_POS_PNL_EN
  localparam bit PNL_EN = 1'b1;
`else
  localparam bit PNL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] side;
    logic [31:0] price;
    logic [31:0] qty;
    logic [31:0] pos;
    logic [31:0] avg;
    logic [31:0] pnl;
    logic [31:0] lside;
    logic [31:0] lprice;
    logic        breach;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic [31:0] side, input logic [31:0] price,
                              input logic [31:0] qty, input logic [31:0] pos,
                              input logic [31:0] avg, input logic [31:0] pnl,
                              input logic [31:0] lside, input logic [31:0] lprice,
                              input logic breach, input int lat);
    vec_t v;
    v.side = side; v.price = price; v.qty = qty;
    v.pos = pos; v.avg = avg; v.pnl = PNL_EN ? pnl : 32'd0;
    v.lside = lside; v.lprice = lprice; v.breach = breach; v.lat = lat;
    return v;
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h (%0d) want 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endfunction

  task automatic check_outputs(input string tag, input vec_t e);
    chk32({tag, ".pos"}, bus.current_position, e.pos);
    chk32({tag, ".avg"}, bus.avg_entry_price, e.avg);
    chk32({tag, ".pnl"}, bus.realized_pnl, e.pnl);
    chk32({tag, ".lside"}, bus.last_fill_side, e.lside);
    chk32({tag, ".lprice"}, bus.last_fill_price, e.lprice);
    chk1({tag, ".breach"}, bus.limit_breach, e.breach);
  endtask

  // Drive one fill, push its expectation, then pop and compare when ap_done appears.
  task automatic run_fill(input vec_t v);
    int c;
    bit got;
    vec_t e;
    sb_q.push_back(v);
    @(negedge ap_clk);
    chk1("done_pulse_end", bus.ap_done, 1'b0);
    chk1("idle_before", bus.ap_idle, 1'b1);
    bus.fill_side = v.side;
    bus.fill_price = v.price;
    bus.fill_qty = v.qty;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    c = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      @(negedge ap_clk);
      c++;
      if (c == 1) begin
        bus.ap_start = 1'b0;
        chk1("idle_drop", bus.ap_idle, 1'b0);
        chk1("ready_drop", bus.ap_ready, 1'b0);
      end
      if (bus.ap_done) got = 1'b1;
    end
    e = sb_q.pop_front();
    chk1("done_seen", got, 1'b1);
    chk32("latency", c, e.lat);
    check_outputs("fill", e);
    $display("fill side=%0d price=%0d qty=%0d -> pos=%0d avg=%0d pnl=%0d breach=%0b lat=%0d",
             v.side, v.price, v.qty, $signed(bus.current_position), bus.avg_entry_price,
             $signed(bus.realized_pnl), bus.limit_breach, c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got;
    bit saw_done;
    vec_t e;

    vecs[0]  = mk(1, 15000, 100,  100,          15000, 0,            1, 15000, 1'b0, 2);
    vecs[1]  = mk(1, 15100, 100,  200,          15050, 0,            1, 15100, 1'b0, 66);
    vecs[2]  = mk(2, 15200, 50,   150,          15050, 7500,         2, 15200, 1'b0, 2);
    vecs[3]  = mk(2, 15000, 300,  -32'sd150,    15000, 0,            2, 15000, 1'b0, 2);
    vecs[4]  = mk(3, 999,   10,   -32'sd150,    15000, 0,            2, 15000, 1'b0, 2);
    vecs[5]  = mk(2, 777,   0,    -32'sd150,    15000, 0,            2, 15000, 1'b0, 2);
    vecs[6]  = mk(2, 14900, 50,   -32'sd200,    14975, 0,            2, 14900, 1'b0, 66);
    vecs[7]  = mk(1, 14800, 200,  0,            0,     35000,        1, 14800, 1'b0, 2);
    vecs[8]  = mk(1, 100,   1001, 1001,         100,   35000,        1, 100,   1'b1, 2);
    vecs[9]  = mk(2, 103,   1,    1000,         100,   35003,        2, 103,   1'b0, 2);
    vecs[10] = mk(1, 101,   3,    1003,         100,   35003,        1, 101,   1'b1, 66);
    vecs[11] = mk(2, 100,   1003, 0,            0,     35003,        2, 100,   1'b0, 2);
    vecs[12] = mk(1, 0,     1,    1,            0,     35003,        1, 0,     1'b0, 2);
    vecs[13] = mk(2, 32'd4000000000, 1, 0,      0,     32'h7FFFFFFF, 2, 32'd4000000000, 1'b0, 2);
    vecs[14] = mk(1, 32'd4000000000, 1, 1,      32'd4000000000, 32'h7FFFFFFF, 1, 32'd4000000000, 1'b0, 2);
    vecs[15] = mk(2, 0,     1,    0,            0,     35003,        2, 0,     1'b0, 2);

    // Reset with ap_start held high: reset must win.
    ap_rst = 1'b1;
    bus.ap_start = 1'b1;
    bus.fill_side = 32'd1;
    bus.fill_price = 32'd1234;
    bus.fill_qty = 32'd5;
    repeat (5) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    bus.ap_start = 1'b0;
    chk1("rst.done", bus.ap_done, 1'b0);
    chk1("rst.idle", bus.ap_idle, 1'b1);
    chk1("rst.ready", bus.ap_ready, 1'b1);
    check_outputs("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0));

    for (int i = 0; i < 16; i++) run_fill(vecs[i]);

    // Back-to-back with ap_start held: exactly one IDLE cycle between transactions.
    @(negedge ap_clk);
    bus.fill_side = 32'd1;
    bus.fill_price = 32'd200;
    bus.fill_qty = 32'd10;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    c = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      @(negedge ap_clk);
      c++;
      if (bus.ap_done) got = 1'b1;
    end
    chk1("b2b.done1_seen", got, 1'b1);
    chk32("b2b.latency1", c, 2);
    chk32("b2b.pos1", bus.current_position, 32'd10);
    chk32("b2b.avg1", bus.avg_entry_price, 32'd200);
    bus.fill_side = 32'd2;
    bus.fill_price = 32'd210;
    bus.fill_qty = 32'd10;
    @(negedge ap_clk);
    chk1("b2b.idle_gap", bus.ap_idle, 1'b1);
    @(negedge ap_clk);
    chk1("b2b.accepted", bus.ap_idle, 1'b0);
    @(negedge ap_clk);
    chk1("b2b.done2", bus.ap_done, 1'b1);
    bus.ap_start = 1'b0;
    check_outputs("b2b", mk(2, 210, 10, 0, 0, 35103, 2, 210, 1'b0, 2));
    $display("fill b2b side=1/2 price=200/210 qty=10 -> pos=%0d pnl=%0d", $signed(bus.current_position),
             $signed(bus.realized_pnl));

    // Abort an add in DIV with reset, then confirm internal state was cleared.
    run_fill(mk(1, 100, 5, 5, 100, 35103, 1, 100, 1'b0, 2));
    @(negedge ap_clk);
    bus.fill_side = 32'd1;
    bus.fill_price = 32'd100;
    bus.fill_qty = 32'd5;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    saw_done = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge ap_clk);
      if (k == 1) bus.ap_start = 1'b0;
      if (bus.ap_done) saw_done = 1'b1;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk1("abort.done", bus.ap_done, 1'b0);
    chk1("abort.idle", bus.ap_idle, 1'b1);
    chk1("abort.ready", bus.ap_ready, 1'b1);
    check_outputs("abort", mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0));
    for (int k = 0; k < 80; k++) begin
      @(negedge ap_clk);
      if (bus.ap_done) saw_done = 1'b1;
    end
    chk1("abort.no_done", saw_done, 1'b0);
    $display("fill abort side=1 price=100 qty=5 -> reset in DIV, pos=%0d", $signed(bus.current_position));

    run_fill(mk(1, 300, 7, 7, 300, 0, 1, 300, 1'b0, 2));
    run_fill(mk(2, 301, 7, 0, 0, 7, 2, 301, 1'b0, 2));

    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    chk32("sb_empty", sb_q.size(), e.pos);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hft_position_tracker.md
# hft_position_tracker

Fill-side feedback engine for the HFT datapath. It accepts one exchange fill per `ap_ctrl_hs` transaction and updates the signed net position, last-fill registers, volume-weighted average entry price and realized PnL. Its outputs drive the `current_position`, `last_fill_price` and `last_fill_side` inputs of the decision core, closing the loop from the order side back to the market-data side.

## Interface
- `POS_LIMIT`, default 1000: absolute position (units) above which `limit_breach` asserts.
- `ap_clk`  in  1  clock; all logic on rising edge.
- `ap_rst`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  start request; sampled only in IDLE.
- `ap_done`  out  1  one-cycle pulse; outputs are valid and updated.
- `ap_idle`  out  1  high only in IDLE.
- `ap_ready`  out  1  high only in IDLE (equals `ap_idle`).
- `fill_side`  in  32  1 = buy, 2 = sell, any other value = no-op.
- `fill_price`  in  32  unsigned, cents.
- `fill_qty`  in  32  unsigned units; 0 = no-op.
- `current_position`  out  32  signed net position.
- `last_fill_price`  out  32  price of the last valid fill.
- `last_fill_side`  out  32  side of the last valid fill.
- `avg_entry_price`  out  32  VWAP of the open position in cents; 0 when flat.
- `realized_pnl`  out  32  signed cumulative PnL in cent-units, saturating.
- `limit_breach`  out  1  level; `|current_position| > POS_LIMIT`.

## Operation
- **Acceptance.** A rising edge with `ap_start`=1 in IDLE registers `fill_*` and moves the FSM to CALC. Inputs are ignored at all other times.
- **FSM.** IDLE → CALC → (DIV) → DONE → IDLE.
- **CALC (1 cycle)** classifies the fill as one of:
  - No-op (invalid side or qty = 0): nothing changes, including `last_fill_*`.
  - Open from flat: pos = ±qty, avg = price, basis = price·qty.
  - Add (same sign as pos): basis += price·qty, pos ±= qty, go to DIV.
  - Reduce (opposite sign, qty ≤ |pos|): close = qty.
  - Flip (qty > |pos|): close = |pos|; remainder opens at avg = price, basis = price·remainder.
- **Reduce and flip.** pnl += (price − avg)·close·sign(old pos). For a reduce, avg is unchanged and basis = avg·|new pos|. If the new pos is 0, avg = 0 and basis = 0.
- **DIV.** Radix-2 restoring divide, avg = basis / |pos|. Fixed 64 cycles; the quotient is truncated.
- **Registers.**
  - basis: 64-bit unsigned.
  - Products: 32×32 → 64-bit.
  - PnL accumulator: 64-bit signed; `realized_pnl` is that value saturated to [−2^31, 2^31−1].
  - Position: 32-bit signed, wrapping. Drivers guarantee |pos| < 2^31.
- **Last-fill registers.** `last_fill_price` and `last_fill_side` update in DONE for every non-no-op fill.
- **`limit_breach`** is registered and updates together with `current_position`.

## Timing
- **Reset.** All outputs = 0 except `ap_idle` = `ap_ready` = 1. Internal basis and accumulators = 0; FSM = IDLE.
- **Reset mid-operation.** `ap_rst` in any state aborts the divide. On the next cycle the FSM is in IDLE with all outputs at reset values. `ap_rst` has priority over `ap_start`.
- **Latency.** Count from the accepting edge E.
  - No-divide paths (no-op, open, reduce, flip): `ap_done`=1 in the cycle after E+1, i.e. exactly 2 cycles after E.
  - Add path: `ap_done` exactly 66 cycles after E.
- **Output update.** All outputs change in the same cycle `ap_done` asserts and hold until the next DONE.
- **Idle/ready.** `ap_idle` and `ap_ready` drop the cycle after E and return high the cycle after DONE.
- **Back-to-back.** With `ap_start` held high, a new fill is accepted on the first IDLE edge, giving exactly one IDLE cycle between transactions.

## Configuration
- `HFT_POS_PNL_EN` defined: realized-PnL multiplier and accumulator are compiled in, as described above.
- `HFT_POS_PNL_EN` undefined: `realized_pnl` is tied to 0 and no closing multiplier is built. Position, avg, last-fill, `limit_breach` and all latencies are identical to the enabled build.

## Test plan
- **Reset.** Assert `ap_rst` 5 cycles → all outputs 0, `ap_idle`=`ap_ready`=1, `ap_done`=0.
- **Open then add.**
  - Buy 100 @ 15000 from flat → `ap_done` at E+2; pos 100, avg 15000, `last_fill_side` 1.
  - Then buy 100 @ 15100 → `ap_done` at E+66; pos 200, avg 15050.
- **Reduce.** Sell 50 @ 15200 → `ap_done` at E+2; pos 150, avg 15050, `realized_pnl` 7500, `last_fill_price` 15200.
- **Flip.** Sell 300 @ 15000 → pnl 7500 − 7500 = 0; pos −150, avg 15000, `last_fill_side` 2.
- **No-op.** `fill_side`=3, then `fill_qty`=0 → each gives `ap_done` at E+2 with every output unchanged.
- **Limit and abort.**
  - Buy 1001 from flat with `POS_LIMIT`=1000 → `limit_breach`=1.
  - Start an add, assert `ap_rst` 10 cycles into DIV → next cycle IDLE with all outputs 0 and no `ap_done` pulse.
